// File: rtl/imem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int IMEM_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } arb_owner_e;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Counter with increment/clear. It either saturates at MAX or, with WRAP set, rolls over.
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1,
  parameter bit               WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (WRAP || (cnt != MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port imem between fetch (default priority) and the loader/debug port.
// Define IMEM_ARB_PERF_EN to add the stall / forced-win performance counters.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int WORD_ADDR_WIDTH = 10,
  parameter int STARVE_MAX      = IMEM_STARVE_MAX
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       f_req,
  input  logic [WORD_ADDR_WIDTH-1:0] f_addr,
  output logic                       f_gnt,
  output logic                       f_rvalid,
  output logic [XLEN-1:0]            f_rdata,
  output logic                       fetch_stall,
  input  logic                       l_req,
  input  logic                       l_we,
  input  logic                       l_lock,
  input  logic [WORD_ADDR_WIDTH-1:0] l_addr,
  input  logic [XLEN-1:0]            l_wdata,
  output logic                       l_gnt,
  output logic                       l_rvalid,
  output logic [XLEN-1:0]            l_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  input  logic [XLEN-1:0]            mem_rdata,
  output arb_state_e                 dbg_state,
  output logic [3:0]                 dbg_starve_cnt
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]                perf_fetch_stall_cnt,
  output logic [31:0]                perf_starve_win_cnt
`endif
);

  // Handshake: a requester holds req (and its address/data) until it sees gnt in the
  // same cycle; a granted read returns data with rvalid exactly one cycle later.

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic [3:0] starve_cnt;
  logic       lock_hold;
  logic       starve_win;

  always_comb begin
    lock_hold   = (state_q == LOCKED) && l_req && l_lock;
    // A forced win only happens under contention; a lone loader request is not "forced".
    starve_win  = !lock_hold && f_req && l_req && (starve_cnt == 4'(STARVE_MAX));
    l_gnt       = reset && l_req && (lock_hold || !f_req || starve_win);
    f_gnt       = reset && f_req && !lock_hold && !starve_win;
    fetch_stall = f_req && !f_gnt;

    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = l_gnt ? l_addr : f_addr;
    mem_wdata = l_gnt ? l_wdata : '0;

    // The release cycle is arbitrated as ARB above, so the next state only needs the grant.
    state_d = (l_gnt && l_lock) ? LOCKED : ARB;
    if (f_gnt)              owner_d = OWN_FETCH;
    else if (l_gnt && !l_we) owner_d = OWN_LOAD;
    else                    owner_d = OWN_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  sat_counter #(
    .WIDTH (4),
    .MAX   (4'(STARVE_MAX)),
    .WRAP  (1'b0)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (l_req && !l_gnt),
    .clr   (l_gnt || !l_req),
    .cnt   (starve_cnt)
  );

  assign f_rvalid       = (owner_q == OWN_FETCH);
  assign l_rvalid       = (owner_q == OWN_LOAD);
  assign f_rdata        = mem_rdata;
  assign l_rdata        = mem_rdata;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt;

`ifdef IMEM_ARB_PERF_EN
  sat_counter #(
    .WIDTH (32),
    .MAX   ('1),
    .WRAP  (1'b1)
  ) u_perf_stall (
    .clk   (clk),
    .rst_n (reset),
    .inc   (fetch_stall),
    .clr   (1'b0),
    .cnt   (perf_fetch_stall_cnt)
  );

  sat_counter #(
    .WIDTH (32),
    .MAX   ('1),
    .WRAP  (1'b1)
  ) u_perf_starve (
    .clk   (clk),
    .rst_n (reset),
    .inc   (starve_win && l_gnt),
    .clr   (1'b0),
    .cnt   (perf_starve_win_cnt)
  );
`endif

  a_one_grant: assert property (@(posedge clk) disable iff (!reset) !(f_gnt && l_gnt));
  a_f_gnt_req: assert property (@(posedge clk) disable iff (!reset) f_gnt |-> f_req);
  a_l_gnt_req: assert property (@(posedge clk) disable iff (!reset) l_gnt |-> l_req);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: reference arbiter model plus read-data scoreboard.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 10;
  localparam int SMAX = IMEM_STARVE_MAX;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            f_req, l_req, l_we, l_lock;
  logic [AW-1:0]   f_addr, l_addr;
  logic [XLEN-1:0] l_wdata;
  logic            f_gnt, f_rvalid, fetch_stall, l_gnt, l_rvalid, mem_en, mem_we;
  logic [XLEN-1:0] f_rdata, l_rdata, mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_rdata = '0;
  arb_state_e      dbg_state;
  logic [3:0]      dbg_starve_cnt;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]     perf_fetch_stall_cnt, perf_starve_win_cnt;
`endif

  imem_arbiter #(.XLEN(XLEN), .WORD_ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .fetch_stall(fetch_stall),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fetch_stall_cnt(perf_fetch_stall_cnt), .perf_starve_win_cnt(perf_starve_win_cnt)
`endif
  );

  function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] a);
    return 32'hA5000000 ^ (32'(a) * 32'h00010003);
  endfunction

  // imem array attached to the DUT: synchronous read, one access per cycle
  logic [XLEN-1:0] mem [1024];
  logic [1023:0]   mem_wr = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]    <= mem_wdata;
        mem_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // reference model state
  logic [XLEN-1:0] ref_mem [1024];
  logic [1023:0]   ref_wr = '0;
  arb_state_e      m_state;
  arb_owner_e      m_owner;
  int              m_starve, m_stall, m_forced;
  logic [XLEN-1:0] f_exp_q[$];
  logic [XLEN-1:0] l_exp_q[$];

  int n_total = 0;
  int n_bad   = 0;
  logic obs_f_gnt, obs_l_gnt, obs_stall;

  function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = ARB;
    m_owner  = OWN_NONE;
    m_starve = 0;
    m_stall  = 0;
    m_forced = 0;
    f_exp_q.delete();
    l_exp_q.delete();
  endtask

  task automatic drive_idle();
    f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_lock = 0; l_addr = '0; l_wdata = '0;
  endtask

  // One clock of stimulus: drive at negedge, check after settling, advance the model.
  task automatic cycle(input logic fr, input logic [AW-1:0] fa, input logic lr,
                       input logic lwe, input logic llk, input logic [AW-1:0] la,
                       input logic [XLEN-1:0] lwd);
    logic e_f, e_l, forced;
    logic [XLEN-1:0] d;
    @(negedge clk);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_lock = llk; l_addr = la; l_wdata = lwd;
    #1;
    check_eq("f_rvalid", 32'(f_rvalid), 32'(m_owner == OWN_FETCH));
    check_eq("l_rvalid", 32'(l_rvalid), 32'(m_owner == OWN_LOAD));
    if (m_owner == OWN_FETCH) begin
      if (f_exp_q.size() == 0) check_eq("f_q_underflow", 32'd1, 32'd0);
      else begin d = f_exp_q.pop_front(); check_eq("f_rdata", f_rdata, d); end
    end
    if (m_owner == OWN_LOAD) begin
      if (l_exp_q.size() == 0) check_eq("l_q_underflow", 32'd1, 32'd0);
      else begin d = l_exp_q.pop_front(); check_eq("l_rdata", l_rdata, d); end
    end
    check_eq("state", 32'(dbg_state), 32'(m_state));
    check_eq("starve_cnt", 32'(dbg_starve_cnt), 32'(m_starve));
`ifdef IMEM_ARB_PERF_EN
    check_eq("perf_stall_run", perf_fetch_stall_cnt, 32'(m_stall));
    check_eq("perf_starve_run", perf_starve_win_cnt, 32'(m_forced));
`endif
    if (m_state == LOCKED && lr && llk) begin
      e_l = 1'b1; e_f = 1'b0; forced = 1'b0;
    end else begin
      forced = fr && lr && (m_starve == SMAX);
      e_l    = lr && (!fr || forced);
      e_f    = fr && !e_l;
    end
    check_eq("f_gnt", 32'(f_gnt), 32'(e_f));
    check_eq("l_gnt", 32'(l_gnt), 32'(e_l));
    check_eq("fetch_stall", 32'(fetch_stall), 32'(fr && !e_f));
    check_eq("mem_en", 32'(mem_en), 32'(e_f || e_l));
    check_eq("mem_we", 32'(mem_we), 32'(e_l && lwe));
    if (e_f) begin
      check_eq("mem_addr_f", 32'(mem_addr), 32'(fa));
      check_eq("mem_wdata_f", mem_wdata, 32'd0);
    end
    if (e_l) check_eq("mem_addr_l", 32'(mem_addr), 32'(la));
    if (e_l && lwe) check_eq("mem_wdata_l", mem_wdata, lwd);
    obs_f_gnt = f_gnt; obs_l_gnt = l_gnt; obs_stall = fetch_stall;
    if (e_f) f_exp_q.push_back(ref_read(fa));
    if (e_l && !lwe) l_exp_q.push_back(ref_read(la));
    if (e_l && lwe) begin ref_mem[la] = lwd; ref_wr[la] = 1'b1; end
    if (fr && !e_f) m_stall++;
    if (forced) m_forced++;
    m_starve = (lr && !e_l) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    m_state  = (e_l && llk) ? LOCKED : ARB;
    m_owner  = e_f ? OWN_FETCH : ((e_l && !lwe) ? OWN_LOAD : OWN_NONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wins, stalls, k, budget;
    model_reset();
    // reset with both requesters active: grants must stay low
    reset = 1'b0;
    drive_idle();
    f_req = 1; l_req = 1; f_addr = 10'h004; l_addr = 10'h008;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_f_gnt", 32'(f_gnt), 32'd0);
    check_eq("rst_l_gnt", 32'(l_gnt), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check_eq("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ARB));
    check_eq("rst_starve", 32'(dbg_starve_cnt), 32'd0);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;

    // fetch only, address 0x004, three cycles
    repeat (3) cycle(1, 10'h004, 0, 0, 0, '0, '0);
    cycle(0, '0, 0, 0, 0, '0, '0);

    // continuous contention: loader should win once every STARVE_MAX+1 cycles
    wins = 0;
    for (int i = 0; i < 3 * (SMAX + 1); i++) begin
      cycle(1, 10'(i), 1, 0, 0, 10'(100 + i), '0);
      wins += int'(obs_l_gnt);
    end
    check_eq("contention_wins", 32'(wins), 32'd3);
    cycle(0, '0, 0, 0, 0, '0, '0);

    // loader write then fetch of same address
    cycle(0, '0, 1, 1, 0, 10'h010, 32'hDEADBEEF);
    cycle(1, 10'h010, 0, 0, 0, '0, '0);
    cycle(0, '0, 0, 0, 0, '0, '0);

    // locked burst of three writes while fetch keeps requesting
    k = 0; budget = 0; stalls = 0;
    while (k < 3 && budget < 20) begin
      cycle(1, 10'h030, 1, 1, 1, 10'(10'h020 + k), 32'hC0DE0000 + 32'(k));
      if (obs_l_gnt) begin k++; stalls += int'(obs_stall); end
      budget++;
    end
    check_eq("burst_done", 32'(k), 32'd3);
    check_eq("burst_stalls", 32'(stalls), 32'd3);
    cycle(1, 10'h020, 0, 0, 0, '0, '0);
    check_eq("lock_exit_fgnt", 32'(obs_f_gnt), 32'd1);
    cycle(1, 10'h021, 0, 0, 0, '0, '0);
    cycle(1, 10'h022, 1, 0, 0, 10'h022, '0);
    cycle(0, '0, 0, 0, 0, '0, '0);

    // random mixed traffic on a small address window
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 10'($urandom_range(0, 15)), $urandom);
    end
    cycle(0, '0, 0, 0, 0, '0, '0);
    cycle(0, '0, 0, 0, 0, '0, '0);

    // reset right after a fetch grant drops the in-flight read
    cycle(1, 10'h005, 1, 0, 0, 10'h006, '0);
    cycle(1, 10'h005, 1, 0, 0, 10'h006, '0);
    @(posedge clk);
    #2;
    check_eq("pre_rst_f_rvalid", 32'(f_rvalid), 32'd1);
    check_eq("pre_rst_starve", 32'(dbg_starve_cnt), 32'd2);
    drive_idle();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check_eq("mid_rst_state", 32'(dbg_state), 32'(ARB));
    check_eq("mid_rst_starve", 32'(dbg_starve_cnt), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle(0, '0, 0, 0, 0, '0, '0);

    // perf scenario: one forced locked win followed by a locked read burst (5 stalls)
    for (int i = 0; i < SMAX + 5; i++) cycle(1, 10'h040, 1, 0, 1, 10'h050, '0);
    cycle(0, '0, 0, 0, 0, '0, '0);
    check_eq("perf_model_stalls", 32'(m_stall), 32'd5);
`ifdef IMEM_ARB_PERF_EN
    check_eq("perf_stall_cnt", perf_fetch_stall_cnt, 32'd5);
    check_eq("perf_starve_cnt", perf_starve_win_cnt, 32'd1);
`endif
    cycle(0, '0, 0, 0, 0, '0, '0);
    check_eq("f_q_empty", 32'(f_exp_q.size()), 32'd0);
    check_eq("l_q_empty", 32'(l_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
